// File: rtl/cro_pkg.sv
// Shared state encoding, default sizing and priority-pick helper for the
// ring-oscillator measurement scheduler.
package cro_pkg;

    localparam int unsigned NUM_CRO_DEF    = 4;
    localparam int unsigned CNT_W_DEF      = 32;
    localparam int unsigned WIN_W_DEF      = 16;
    localparam int unsigned SETTLE_CYC_DEF = 8;
    localparam int unsigned MASK_MAX       = 32;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        MEASURE,
        REPORT,
        FINISH
    } state_t;

    // Lowest set bit wins; an empty mask yields 0 (callers test for empty first).
    function automatic int unsigned lowest_set(input logic [MASK_MAX-1:0] mask);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = MASK_MAX; i > 0; i--) begin
            if (mask[i-1]) idx = i - 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cro_meas_sched_if.sv
// Result channel of the measurement scheduler: one oscillator index and its
// edge count per valid/ready transfer.
interface cro_meas_sched_if import cro_pkg::*; #(
    parameter int unsigned NUM_CRO = NUM_CRO_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
);
    localparam int unsigned SEL_W = (NUM_CRO > 1) ? $clog2(NUM_CRO) : 1;

    logic             res_valid;
    logic             res_ready;
    logic [SEL_W-1:0] res_idx;
    logic [CNT_W-1:0] res_count;

    modport master (output res_valid, res_idx, res_count, input res_ready);
    modport slave  (input res_valid, res_idx, res_count, output res_ready);

endinterface

// File: rtl/cro_edge_cnt.sv
// Saturating edge counter with synchronous clear; holds at all-ones.
module cro_edge_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cro_meas_sched.sv
// Sequences the selected ring oscillators through settle and counting windows
// on one shared edge counter and reports each count over the result channel.
module cro_meas_sched import cro_pkg::*; #(
    parameter  int unsigned NUM_CRO    = NUM_CRO_DEF,
    parameter  int unsigned CNT_W      = CNT_W_DEF,
    parameter  int unsigned WIN_W      = WIN_W_DEF,
    parameter  int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    localparam int unsigned SEL_W      = (NUM_CRO > 1) ? $clog2(NUM_CRO) : 1
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               start,
    input  logic               abort,
    input  logic [NUM_CRO-1:0] cro_mask,
    input  logic [WIN_W-1:0]   win_len,
    input  logic               osc_pulse,
    output logic [NUM_CRO-1:0] cro_en,
    output logic [SEL_W-1:0]   cro_sel,
    output logic               busy,
    output logic               done,
    cro_meas_sched_if.master   res
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_CRO-1:0] mask_q;
    logic [WIN_W-1:0]   win_q;
    logic [TMR_W-1:0]   tmr;
    logic [CNT_W-1:0]   count;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               hs;

    cro_edge_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (ACLK),
        .rst   (ARESET),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (count)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        hs            = 1'b0;
        busy          = (state != IDLE);
        done          = (state == FINISH);
        cro_en        = '0;
        res.res_valid = (state == REPORT);
        res.res_idx   = cro_sel;
        res.res_count = count;

        case (state)
            IDLE:    if (start) state_nxt = SELECT;
            SELECT: begin
                cnt_clr   = (mask_q != '0);
                state_nxt = (mask_q == '0) ? FINISH : SETTLE;
            end
            SETTLE: begin
                cro_en[cro_sel] = 1'b1;
                if (tmr == '0) state_nxt = MEASURE;
            end
            MEASURE: begin
                cro_en[cro_sel] = 1'b1;
                cnt_inc         = osc_pulse;
                if (tmr == '0) state_nxt = REPORT;
            end
            REPORT: begin
                if (res.res_ready) begin
                    hs        = 1'b1;
                    state_nxt = SELECT;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Abort overrides everything, including a start in IDLE and a REPORT handshake.
        if (abort) begin
            state_nxt = IDLE;
            hs        = 1'b0;
            cnt_inc   = 1'b0;
            cnt_clr   = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mask_q  <= '0;
            win_q   <= '0;
            cro_sel <= '0;
            tmr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        mask_q <= cro_mask;
                        win_q  <= (win_len == '0) ? WIN_W'(1) : win_len;
                    end
                end
                SELECT: begin
                    cro_sel <= SEL_W'(lowest_set(MASK_MAX'(mask_q)));
                    tmr     <= TMR_W'(SETTLE_CYC - 1);
                end
                SETTLE: begin
                    if (tmr == '0) tmr <= TMR_W'(win_q) - TMR_W'(1);
                    else           tmr <= tmr - TMR_W'(1);
                end
                MEASURE: tmr <= tmr - TMR_W'(1);
                REPORT: begin
                    if (hs) mask_q <= mask_q & ~(NUM_CRO'(1) << cro_sel);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cro_meas_sched.sv
// Randomized scoreboard bench for cro_meas_sched against a timeline model of
// the sweep (select, settle, window, report) computed per start request.
module tb_cro_meas_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned WW = 16;
    localparam int unsigned SC = 5;
    localparam int          PL = 2048;

    typedef struct {
        int unsigned       idx;
        longint unsigned   cnt;
        int                cyc;
    } res_t;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          start, abort, osc_pulse;
    logic [N-1:0]  cro_mask;
    logic [WW-1:0] win_len;
    logic [N-1:0]  cro_en;
    logic [1:0]    cro_sel;
    logic          busy, done;

    logic          s_start, s_abort, s_pulse;
    logic [N-1:0]  s_mask;
    logic [WW-1:0] s_win;
    logic [N-1:0]  s_en;
    logic [1:0]    s_sel;
    logic          s_busy, s_done;

    cro_meas_sched_if #(.NUM_CRO(N), .CNT_W(CW)) res_if ();
    cro_meas_sched_if #(.NUM_CRO(N), .CNT_W(4))  sat_if ();

    cro_meas_sched #(.NUM_CRO(N), .CNT_W(CW), .WIN_W(WW), .SETTLE_CYC(SC)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
        .cro_mask(cro_mask), .win_len(win_len), .osc_pulse(osc_pulse),
        .cro_en(cro_en), .cro_sel(cro_sel), .busy(busy), .done(done), .res(res_if)
    );

    cro_meas_sched #(.NUM_CRO(N), .CNT_W(4), .WIN_W(WW), .SETTLE_CYC(SC)) dut_sat (
        .ACLK(ACLK), .ARESET(ARESET), .start(s_start), .abort(s_abort),
        .cro_mask(s_mask), .win_len(s_win), .osc_pulse(s_pulse),
        .cro_en(s_en), .cro_sel(s_sel), .busy(s_busy), .done(s_done), .res(sat_if)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    res_t         exp_q[$];
    int           done_q[$];
    logic [N-1:0] en_exp[int];
    bit           busy_exp[int];

    bit pulse_pat[PL];
    bit ready_pat[PL];
    bit start_noise[PL];

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cro_en", cro_en, 0);
        chk("rst_cro_sel", cro_sel, 0);
        chk("rst_res_valid", res_if.res_valid, 0);
        chk("rst_res_idx", res_if.res_idx, 0);
        chk("rst_res_count", res_if.res_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    // pm: 0 random, 1 every 2nd cycle, 2 always high.  rm: 0 random, 1 always, 2 low below zlim.
    task automatic gen_pats(input int pm, input int rm, input int zlim);
        for (int o = 0; o < PL; o++) begin
            pulse_pat[o]   = (pm == 0) ? bit'($urandom_range(0, 1)) : (pm == 1) ? bit'(o % 2) : 1'b1;
            ready_pat[o]   = (rm == 0) ? ((o >= 1500) || bit'($urandom_range(0, 1))) :
                             (rm == 1) ? 1'b1 : (o >= zlim);
            start_noise[o] = ($urandom_range(0, 7) == 0);
        end
    endtask

    // Offsets are cycles relative to the one in which start is driven.
    task automatic model(input logic [N-1:0] mask, input int unsigned win, input int k0,
                         input int cut, output int dlen);
        int              s, w, d, m0, h;
        longint unsigned c, cmax;
        logic [N-1:0]    oh;
        cmax = (64'd1 << CW) - 1;
        w    = (win == 0) ? 1 : int'(win);
        s    = 1;
        for (int unsigned i = 0; i < N; i++) begin
            if (mask[i]) begin
                m0 = s + 1 + SC;
                c  = 0;
                for (int o = m0; o < m0 + w; o++) if (pulse_pat[o]) c++;
                if (c > cmax) c = cmax;
                oh    = '0;
                oh[i] = 1'b1;
                for (int o = s + 1; o < m0 + w; o++) if (o <= cut) en_exp[k0 + o] = oh;
                h = m0 + w;
                while (h < PL - 1 && !ready_pat[h]) h++;
                if (h < cut) exp_q.push_back('{idx: i, cnt: c, cyc: k0 + h});
                s = h + 1;
            end
        end
        d = s + 1;
        if (d < cut) done_q.push_back(k0 + d);
        for (int o = 1; o <= d && o <= cut; o++) busy_exp[k0 + o] = 1'b1;
        dlen = (d < cut) ? d : cut;
    endtask

    task automatic run_sweep(input logic [N-1:0] mask, input int unsigned win,
                             input int cut, input bit use_rst);
        int k0, dlen;
        @(posedge ACLK); #1;
        k0 = cyc;
        model(mask, win, k0, cut, dlen);
        start     = 1'b1;
        cro_mask  = mask;
        win_len   = WW'(win);
        osc_pulse = pulse_pat[0];
        res_if.res_ready = ready_pat[0];
        for (int o = 1; o <= dlen; o++) begin
            @(posedge ACLK); #1;
            start     = (o < dlen) && start_noise[o];
            cro_mask  = N'($urandom);
            win_len   = WW'($urandom);
            osc_pulse = pulse_pat[o];
            res_if.res_ready = ready_pat[o];
            if (o == cut) begin
                if (use_rst) ARESET = 1'b1;
                else         abort  = 1'b1;
            end
        end
        @(posedge ACLK); #1;
        if (use_rst) begin
            chk_reset_outputs();
            ARESET = 1'b0;
        end
        start = 1'b0;
        abort = 1'b0;
        osc_pulse = 1'b0;
        res_if.res_ready = 1'b1;
        repeat (3) @(posedge ACLK);
    endtask

    always @(negedge ACLK) begin
        if (mon_en) begin
            chk("cro_en", cro_en, en_exp.exists(cyc) ? en_exp[cyc] : '0);
            chk("busy", busy, busy_exp.exists(cyc) ? 1 : 0);
            chk("done", done, (done_q.size() > 0 && done_q[0] == cyc) ? 1 : 0);
            while (done_q.size() > 0 && done_q[0] <= cyc) void'(done_q.pop_front());
            if (res_if.res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    chk("res_idx", res_if.res_idx, exp_q[0].idx);
                    chk("res_count", res_if.res_count, exp_q[0].cnt);
                    if (res_if.res_ready) begin
                        chk("hs_cycle", cyc, exp_q[0].cyc);
                        void'(exp_q.pop_front());
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                chk("missed_result", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bit              got;
        longint unsigned sat_exp;
        ARESET = 1'b1; start = 1'b0; abort = 1'b0; osc_pulse = 1'b0;
        cro_mask = '0; win_len = '0; res_if.res_ready = 1'b1;
        s_start = 1'b0; s_abort = 1'b0; s_pulse = 1'b1; s_mask = '0; s_win = '0;
        sat_if.res_ready = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        chk_reset_outputs();
        ARESET = 1'b0;
        mon_en = 1'b1;

        gen_pats(0, 0, 0);  run_sweep(4'b0000, 7, PL, 1'b0);
        gen_pats(1, 1, 0);  run_sweep(4'b0101, 100, PL, 1'b0);
        gen_pats(0, 2, 37); run_sweep(4'b1000, 10, PL, 1'b0);
        gen_pats(0, 0, 0);  run_sweep(4'b0110, 0, PL, 1'b0);
        gen_pats(2, 1, 0);  run_sweep(4'b1111, 20, SC + 4, 1'b0);
        gen_pats(0, 0, 0);  run_sweep(4'b1111, 12, PL, 1'b0);
        for (int t = 0; t < 20; t++) begin
            gen_pats(0, 0, 0);
            run_sweep(N'($urandom_range(0, 15)), $urandom_range(0, 40), PL, 1'b0);
        end
        gen_pats(0, 0, 0);  run_sweep(4'b1111, 20, SC + 6, 1'b1);

        sat_exp = (40 < 15) ? 40 : 15;
        @(posedge ACLK); #1;
        s_mask = 4'b0010; s_win = 16'd40; s_start = 1'b1;
        @(posedge ACLK); #1;
        s_start = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge ACLK);
            if (sat_if.res_valid) got = 1'b1;
        end
        chk("sat_timeout", got, 1);
        if (got) begin
            chk("sat_count", sat_if.res_count, sat_exp);
            chk("sat_idx", sat_if.res_idx, 1);
        end

        repeat (40) @(posedge ACLK);
        chk("results_left", exp_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
